vx_tex_issue_arb: RTL

//  Sits between the GPU functional unit's issue port and VX_tex_unit: steers INST_GPU_TEX ops to the tex request port.
//  Non-tex (warp-control) ops bypass the tex unit.

---
 rtl/vx_tex_issue_arb_pkg.sv | 34 +++
 rtl/vx_tex_issue_arb_if.sv | 75 +++++++
 rtl/vx_tex_out_queue.sv | 69 ++++++
 rtl/vx_tex_issue_arb.sv | 134 +++++++++++++
 4 files changed

// File: rtl/vx_tex_issue_arb_pkg.sv
// Shared types for the texture issue arbiter: opcode, instruction tag, commit entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vx_tex_issue_arb_pkg;

  localparam int NUM_LANES  = 4;
  localparam int NUM_WARPS  = 4;
  localparam int UUID_WIDTH = 44;
  localparam int NTEX_BITS  = 1;
  localparam int WID_W      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int LANE_DATAW = NUM_LANES * 32;

  localparam logic [3:0] INST_GPU_TEX = 4'd6;

  // Instruction tag carried alongside every request, response and commit.
  typedef struct packed {
    logic [UUID_WIDTH-1:0] uuid;
    logic [WID_W-1:0]      wid;
    logic [NUM_LANES-1:0]  tmask;
    logic [31:0]           PC;
    logic [4:0]            rd;
    logic                  wb;
  } tex_tag_t;

  localparam int TAG_W     = $bits(tex_tag_t);
  localparam int RSP_DATAW = TAG_W + LANE_DATAW;

  // One commit-stream entry: tag plus per-lane result data.
  typedef struct packed {
    tex_tag_t              tag;
    logic [LANE_DATAW-1:0] data;
  } commit_t;

endpackage

// File: rtl/vx_tex_issue_arb_if.sv
// Bundles the issue, tex request, tex response and commit handshakes of the arbiter.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on every channel; slave = arbiter, master = surrounding pipeline.
interface vx_tex_issue_arb_if;
  import vx_tex_issue_arb_pkg::*;

  logic                  gpu_valid, gpu_ready;
  logic [3:0]            gpu_op_type;
  logic [2:0]            gpu_op_mod;
  logic [UUID_WIDTH-1:0] gpu_uuid;
  logic [WID_W-1:0]      gpu_wid;
  logic [NUM_LANES-1:0]  gpu_tmask;
  logic [31:0]           gpu_PC;
  logic [4:0]            gpu_rd;
  logic                  gpu_wb;
  logic [LANE_DATAW-1:0] gpu_rs1_data, gpu_rs2_data, gpu_rs3_data;

  logic                    tex_req_valid, tex_req_ready;
  logic [UUID_WIDTH-1:0]   tex_req_uuid;
  logic [WID_W-1:0]        tex_req_wid;
  logic [NUM_LANES-1:0]    tex_req_tmask;
  logic [31:0]             tex_req_PC;
  logic [4:0]              tex_req_rd;
  logic                    tex_req_wb;
  logic [NTEX_BITS-1:0]    tex_req_unit;
  logic [2*LANE_DATAW-1:0] tex_req_coords;
  logic [LANE_DATAW-1:0]   tex_req_lod;

  logic                  tex_rsp_valid, tex_rsp_ready;
  logic [UUID_WIDTH-1:0] tex_rsp_uuid;
  logic [WID_W-1:0]      tex_rsp_wid;
  logic [NUM_LANES-1:0]  tex_rsp_tmask;
  logic [31:0]           tex_rsp_PC;
  logic [4:0]            tex_rsp_rd;
  logic                  tex_rsp_wb;
  logic [LANE_DATAW-1:0] tex_rsp_data;

  logic                  out_valid, out_ready;
  logic [UUID_WIDTH-1:0] out_uuid;
  logic [WID_W-1:0]      out_wid;
  logic [NUM_LANES-1:0]  out_tmask;
  logic [31:0]           out_PC;
  logic [4:0]            out_rd;
  logic                  out_wb;
  logic [LANE_DATAW-1:0] out_data;

  modport slave (
    input  gpu_valid, gpu_op_type, gpu_op_mod, gpu_uuid, gpu_wid, gpu_tmask, gpu_PC,
           gpu_rd, gpu_wb, gpu_rs1_data, gpu_rs2_data, gpu_rs3_data,
    output gpu_ready,
    output tex_req_valid, tex_req_uuid, tex_req_wid, tex_req_tmask, tex_req_PC,
           tex_req_rd, tex_req_wb, tex_req_unit, tex_req_coords, tex_req_lod,
    input  tex_req_ready,
    input  tex_rsp_valid, tex_rsp_uuid, tex_rsp_wid, tex_rsp_tmask, tex_rsp_PC,
           tex_rsp_rd, tex_rsp_wb, tex_rsp_data,
    output tex_rsp_ready,
    output out_valid, out_uuid, out_wid, out_tmask, out_PC, out_rd, out_wb, out_data,
    input  out_ready
  );

  modport master (
    output gpu_valid, gpu_op_type, gpu_op_mod, gpu_uuid, gpu_wid, gpu_tmask, gpu_PC,
           gpu_rd, gpu_wb, gpu_rs1_data, gpu_rs2_data, gpu_rs3_data,
    input  gpu_ready,
    input  tex_req_valid, tex_req_uuid, tex_req_wid, tex_req_tmask, tex_req_PC,
           tex_req_rd, tex_req_wb, tex_req_unit, tex_req_coords, tex_req_lod,
    output tex_req_ready,
    output tex_rsp_valid, tex_rsp_uuid, tex_rsp_wid, tex_rsp_tmask, tex_rsp_PC,
           tex_rsp_rd, tex_rsp_wb, tex_rsp_data,
    input  tex_rsp_ready,
    input  out_valid, out_uuid, out_wid, out_tmask, out_PC, out_rd, out_wb, out_data,
    output out_ready
  );

endinterface

// File: rtl/vx_tex_out_queue.sv
// 2-entry FIFO with registered outputs holding the merged commit stream.
// Latency: enqueue -> out_valid_o one cycle.
// Backpressure: in_ready_o drops only when both entries are held and out_ready_i is low.
module vx_tex_out_queue #(
  parameter int DATAW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [DATAW-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [DATAW-1:0] out_data_o
);

  logic [1:0]       count_q, count_d;
  logic [DATAW-1:0] head_q, head_d, tail_q, tail_d;
  logic             enq, deq;

  // A full queue still accepts when the head leaves in the same cycle.
  assign in_ready_o  = (count_q != 2'd2) | out_ready_i;
  assign enq         = in_valid_i & in_ready_o;
  assign deq         = (count_q != 2'd0) & out_ready_i;
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = head_q;

  // Head is always the oldest entry; tail only fills when head is occupied and stays.
  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (count_q)
      2'd0: if (enq) begin
        head_d  = in_data_i;
        count_d = 2'd1;
      end
      2'd1: begin
        if (enq && deq) begin
          head_d = in_data_i;
        end else if (enq) begin
          tail_d  = in_data_i;
          count_d = 2'd2;
        end else if (deq) begin
          count_d = 2'd0;
        end
      end
      default: if (deq) begin
        head_d = tail_q;
        if (enq) tail_d = in_data_i;
        else     count_d = 2'd1;
      end
    endcase
  end

  // Queue state registers; reset flushes everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: rtl/vx_tex_issue_arb.sv
// Steers tex ops to the tex unit, bypasses warp-ctl ops, merges both into one commit queue.
// Latency: tex request combinational; commit one cycle after enqueue. Optional GPU_TEX_PERF_EN adds counters.
// Backpressure: tex issue stalls on tex_req_ready or exhausted credit; bypass stalls on tex response or full queue.
module vx_tex_issue_arb
  import vx_tex_issue_arb_pkg::*;
#(
  parameter int MAX_PENDING = 8,
  localparam int PEND_W = $clog2(MAX_PENDING + 1)
) (
  input  logic              clk,
  input  logic              reset,
  vx_tex_issue_arb_if.slave bus,
  output logic [PEND_W-1:0] pending
`ifdef GPU_TEX_PERF_EN
  ,
  output logic [43:0]       perf_tex_reqs,
  output logic [43:0]       perf_tex_stalls
`endif
);

  localparam logic [PEND_W-1:0] MAX_P = PEND_W'(MAX_PENDING);

  logic              run_q;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic              is_tex, credit_ok, q_in_rdy;
  logic              req_fire, rsp_fire, byp_fire;
  tex_tag_t          gpu_tag, rsp_tag;
  commit_t           enq_dat, head_dat;
  logic [1:0]        unused_op_mod;

  assign unused_op_mod = bus.gpu_op_mod[2:NTEX_BITS];

  assign is_tex    = (bus.gpu_op_type == INST_GPU_TEX);
  assign credit_ok = (pending_q < MAX_P);

  assign gpu_tag = '{uuid: bus.gpu_uuid, wid: bus.gpu_wid, tmask: bus.gpu_tmask,
                     PC: bus.gpu_PC, rd: bus.gpu_rd, wb: bus.gpu_wb};
  assign rsp_tag = '{uuid: bus.tex_rsp_uuid, wid: bus.tex_rsp_wid, tmask: bus.tex_rsp_tmask,
                     PC: bus.tex_rsp_PC, rd: bus.tex_rsp_rd, wb: bus.tex_rsp_wb};

  // All ready/valid outputs stay low until the first clock after reset release.
  assign bus.tex_req_valid = run_q & bus.gpu_valid & is_tex & credit_ok;
  assign bus.tex_rsp_ready = run_q & q_in_rdy;
  assign bus.gpu_ready     = run_q & (is_tex ? (bus.tex_req_ready & credit_ok)
                                             : (~bus.tex_rsp_valid & q_in_rdy));

  assign bus.tex_req_uuid   = bus.gpu_uuid;
  assign bus.tex_req_wid    = bus.gpu_wid;
  assign bus.tex_req_tmask  = bus.gpu_tmask;
  assign bus.tex_req_PC     = bus.gpu_PC;
  assign bus.tex_req_rd     = bus.gpu_rd;
  assign bus.tex_req_wb     = bus.gpu_wb;
  assign bus.tex_req_unit   = bus.gpu_op_mod[NTEX_BITS-1:0];
  assign bus.tex_req_coords = {bus.gpu_rs2_data, bus.gpu_rs1_data};
  assign bus.tex_req_lod    = bus.gpu_rs3_data;

  // Bypass ready already excludes a pending tex response, so at most one enqueue per cycle.
  assign req_fire = bus.tex_req_valid & bus.tex_req_ready;
  assign rsp_fire = bus.tex_rsp_valid & bus.tex_rsp_ready;
  assign byp_fire = bus.gpu_valid & ~is_tex & bus.gpu_ready;

  // Select the queue input: tex response wins, warp-ctl result commits rs1 with wb cleared.
  always_comb begin
    enq_dat = '0;
    if (rsp_fire) begin
      enq_dat.tag  = rsp_tag;
      enq_dat.data = bus.tex_rsp_data;
    end else begin
      enq_dat.tag    = gpu_tag;
      enq_dat.tag.wb = 1'b0;
      enq_dat.data   = bus.gpu_rs1_data;
    end
  end

  vx_tex_out_queue #(.DATAW(RSP_DATAW)) u_out_queue (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (rsp_fire | byp_fire),
    .in_ready_o  (q_in_rdy),
    .in_data_i   (enq_dat),
    .out_valid_o (bus.out_valid),
    .out_ready_i (bus.out_ready),
    .out_data_o  (head_dat)
  );

  assign bus.out_uuid  = head_dat.tag.uuid;
  assign bus.out_wid   = head_dat.tag.wid;
  assign bus.out_tmask = head_dat.tag.tmask;
  assign bus.out_PC    = head_dat.tag.PC;
  assign bus.out_rd    = head_dat.tag.rd;
  assign bus.out_wb    = head_dat.tag.wb;
  assign bus.out_data  = head_dat.data;

  // Credit count; a response with nothing outstanding (stale after reset) saturates at 0.
  always_comb begin
    pending_d = pending_q;
    if (req_fire && !rsp_fire)
      pending_d = pending_q + PEND_W'(1);
    else if (!req_fire && rsp_fire && (pending_q != '0))
      pending_d = pending_q - PEND_W'(1);
  end

  // Run flag and credit counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q     <= 1'b0;
      pending_q <= '0;
    end else begin
      run_q     <= 1'b1;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

`ifdef GPU_TEX_PERF_EN
  logic [43:0] perf_reqs_q, perf_stalls_q;

  // Free-running event counters, wrapping on overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_reqs_q   <= '0;
      perf_stalls_q <= '0;
    end else begin
      if (req_fire) perf_reqs_q <= perf_reqs_q + 44'd1;
      if (bus.gpu_valid && is_tex && !bus.gpu_ready) perf_stalls_q <= perf_stalls_q + 44'd1;
    end
  end

  assign perf_tex_reqs   = perf_reqs_q;
  assign perf_tex_stalls = perf_stalls_q;
`endif

endmodule
